// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and baud divider helper.
// Used by uart_send now and by uart_recv / a future uart_baud_gen.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_send_if.sv
// Request/busy handshake between the control stage (master) and the UART transmitter (slave).
// The byte must stay stable from the send_en rise until tx_busy rises.
interface uart_send_if;
    logic       send_en;
    logic [7:0] send_data;
    logic       tx_busy;

    modport master (output send_en, output send_data, input tx_busy);
    modport slave  (input send_en, input send_data, output tx_busy);
endinterface

// File: rtl/uart_send.sv
// 8N1 UART transmitter: uart_txd falls 3 edges after a send_en rise, each bit lasts BPS_CNT cycles.
// No queueing: a send_en rise while a frame is in progress is dropped; tx_busy covers the whole frame.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    uart_send_if.slave ctrl,
    output logic       uart_txd
);

    localparam int               BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int               CNT_W    = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t      state, state_nxt;
    logic             en_in, en_d0, en_d1;
    logic             en_flag;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic             bit_end;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       tx_data, tx_data_nxt;
    logic             tx_busy, busy_nxt;
    logic             txd_nxt;

    // send_en is captured once before the edge-detect pair so the pin
    // reaches the FSM only through registers (start bit on the 3rd edge).
    assign en_flag = en_d0 & ~en_d1;
    assign bit_end = (baud_cnt == CNT_LAST);
    assign ctrl.tx_busy = tx_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_flag) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && bit_idx == IDX_LAST) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        txd_nxt     = uart_txd;
        busy_nxt    = tx_busy;
        bit_idx_nxt = bit_idx;
        tx_data_nxt = tx_data;
        baud_nxt    = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (en_flag) begin
                    tx_data_nxt = ctrl.send_data;
                    busy_nxt    = 1'b1;
                    txd_nxt     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_nxt     = tx_data[0];
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        txd_nxt = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        txd_nxt     = tx_data[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) busy_nxt = 1'b0;
            end
            default: txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_in    <= 1'b0;
            en_d0    <= 1'b0;
            en_d1    <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx_data  <= 8'd0;
            tx_busy  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            en_in    <= ctrl.send_en;
            en_d0    <= en_in;
            en_d1    <= en_d0;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_idx_nxt;
            tx_data  <= tx_data_nxt;
            tx_busy  <= busy_nxt;
            uart_txd <= txd_nxt;
        end
    end

endmodule
